// File: rtl/adc_hysteresis_trigger_pkg.sv
// adc_hysteresis_trigger_pkg: FSM encoding and default thresholds for the hysteresis trigger
package adc_hysteresis_trigger_pkg;
  typedef enum logic [1:0] {
    LOW       = 2'b00,
    PEND_HIGH = 2'b01,
    HIGH      = 2'b10,
    PEND_LOW  = 2'b11
  } trig_state_t;
  localparam int HIGH_THRESHOLD = -100;
  localparam int LOW_THRESHOLD  = -150;
endpackage

// File: rtl/adc_hysteresis_trigger_sample_qualifier.sv
// adc_hysteresis_trigger_sample_qualifier: signed threshold compares and registered config check
module adc_hysteresis_trigger_sample_qualifier #(
  parameter int ADC_WIDTH = 14
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic [ADC_WIDTH-1:0] sample,
  input  logic [ADC_WIDTH-1:0] high_threshold,
  input  logic [ADC_WIDTH-1:0] low_threshold,
  output logic                 qh,
  output logic                 ql,
  output logic                 cfg_bad,
  output logic                 cfg_error
);
  assign qh      = $signed(sample) >= $signed(high_threshold);
  assign ql      = $signed(sample) <= $signed(low_threshold);
  assign cfg_bad = $signed(high_threshold) <= $signed(low_threshold);
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) cfg_error <= 1'b0;
    else cfg_error <= cfg_bad;
endmodule

// File: rtl/adc_hysteresis_trigger.sv
// adc_hysteresis_trigger: hysteresis + consecutive-sample filter turning ADC samples into a square wave
module adc_hysteresis_trigger
  import adc_hysteresis_trigger_pkg::*;
#(
  parameter int ADC_WIDTH        = 14,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int HOLD_WIDTH       = 8
) (
  input  logic                        clk,
  input  logic                        aresetn,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [ADC_WIDTH-1:0]        high_threshold,
  input  logic [ADC_WIDTH-1:0]        low_threshold,
  input  logic [HOLD_WIDTH-1:0]       hold_samples,
  output logic                        trig_out,
  output logic                        rise_pulse,
  output logic                        fall_pulse,
  output logic                        cfg_error
);
  trig_state_t           state, state_d;
  logic [HOLD_WIDTH-1:0] hold_cnt, cnt_d, n_eff, cnt_inc;
  logic                  qh, ql, cfg_bad, ready_q, unused_tdata;
  assign unused_tdata = ^s_axis_tdata[AXIS_TDATA_WIDTH-1:ADC_WIDTH];
  adc_hysteresis_trigger_sample_qualifier #(.ADC_WIDTH(ADC_WIDTH)) u_qual (
    .clk            (clk),
    .aresetn        (aresetn),
    .sample         (s_axis_tdata[ADC_WIDTH-1:0]),
    .high_threshold (high_threshold),
    .low_threshold  (low_threshold),
    .qh             (qh),
    .ql             (ql),
    .cfg_bad        (cfg_bad),
    .cfg_error      (cfg_error)
  );
  assign n_eff   = hold_samples == '0 ? HOLD_WIDTH'(1) : hold_samples;
  assign cnt_inc = &hold_cnt ? hold_cnt : hold_cnt + 1'b1;
  // a pending state completes on >= so lowering the hold mid-streak finishes on the next qualifier
  always_comb begin
    state_d = state;
    cnt_d   = hold_cnt;
    if (cfg_bad) cnt_d = '0;
    else if (s_axis_tvalid)
      case (state)
        LOW: if (qh) begin
          state_d = n_eff == HOLD_WIDTH'(1) ? HIGH : PEND_HIGH;
          cnt_d   = n_eff == HOLD_WIDTH'(1) ? '0 : HOLD_WIDTH'(1);
        end
        PEND_HIGH: begin
          state_d = !qh ? LOW : cnt_inc >= n_eff ? HIGH : PEND_HIGH;
          cnt_d   = qh && cnt_inc < n_eff ? cnt_inc : '0;
        end
        HIGH: if (ql) begin
          state_d = n_eff == HOLD_WIDTH'(1) ? LOW : PEND_LOW;
          cnt_d   = n_eff == HOLD_WIDTH'(1) ? '0 : HOLD_WIDTH'(1);
        end
        default: begin
          state_d = !ql ? HIGH : cnt_inc >= n_eff ? LOW : PEND_LOW;
          cnt_d   = ql && cnt_inc < n_eff ? cnt_inc : '0;
        end
      endcase
  end
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) begin
      state      <= LOW;
      hold_cnt   <= '0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state      <= state_d;
      hold_cnt   <= cnt_d;
      rise_pulse <= state_d[1] & ~state[1];
      fall_pulse <= ~state_d[1] & state[1];
      ready_q    <= 1'b1;
    end
  // HIGH and PEND_LOW share bit 1, so the output is simply the registered state's top bit
  assign trig_out      = state[1];
  assign s_axis_tready = ready_q;
endmodule

// File: tb/tb_adc_hysteresis_trigger.sv
// tb_adc_hysteresis_trigger: directed vectors with a queue-based scoreboard
module tb_adc_hysteresis_trigger;
  import adc_hysteresis_trigger_pkg::*;
  logic        clk = 1'b0;
  logic        aresetn = 1'b1;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [13:0] high_threshold = 14'(HIGH_THRESHOLD);
  logic [13:0] low_threshold = 14'(LOW_THRESHOLD);
  logic [7:0]  hold_samples = 8'd1;
  logic        trig_out, rise_pulse, fall_pulse, cfg_error;
  logic [4:0]  exp_q[$];
  string       tag_q[$];
  int          n_checks = 0;
  int          n_fails = 0;
  adc_hysteresis_trigger dut (
    .clk            (clk),
    .aresetn        (aresetn),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .high_threshold (high_threshold),
    .low_threshold  (low_threshold),
    .hold_samples   (hold_samples),
    .trig_out       (trig_out),
    .rise_pulse     (rise_pulse),
    .fall_pulse     (fall_pulse),
    .cfg_error      (cfg_error)
  );
  always #5 clk = ~clk;
  function automatic logic [4:0] act_vec();
    return {s_axis_tready, cfg_error, trig_out, rise_pulse, fall_pulse};
  endfunction
  task automatic check(input string name, input logic [4:0] act, input logic [4:0] e);
    n_checks++;
    if (act !== e) begin
      n_fails++;
      $display("FAIL %s: got {rdy,cfg,trig,rise,fall}=%b expected %b", name, act, e);
    end
  endtask
  // monitor: outputs are checked 2 time units after every rising edge
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) check(tag_q.pop_front(), act_vec(), exp_q.pop_front());
  end
  // drive one sample at a falling edge; its response is expected after the next rising edge
  task automatic step(input string name, input logic v, input int x, input logic [4:0] e);
    logic [31:0] r;
    r = $urandom();
    s_axis_tvalid = v;
    s_axis_tdata  = {r[31:14], 14'(x)};
    exp_q.push_back(e);
    tag_q.push_back(name);
    @(negedge clk);
  endtask
  task automatic reset_pulse(input string name);
    s_axis_tvalid = 1'b0;
    aresetn = 1'b0;
    #1;
    check(name, act_vec(), 5'b00000);
    @(negedge clk);
    aresetn = 1'b1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, pending=%0d expected 0", exp_q.size());
    $fatal(1, "timeout");
  end
  initial begin
    #2 aresetn = 1'b0;
    #1 check("reset_state", act_vec(), 5'b00000);
    @(negedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    step("idle", 1'b0, 0, 5'b10000);
    hold_samples = 8'd1;
    step("n1_s1", 1'b1, -200, 5'b10000);
    step("n1_s2", 1'b1, -90,  5'b10110);
    step("n1_s3", 1'b1, -120, 5'b10100);
    step("n1_s4", 1'b1, -160, 5'b10001);
    hold_samples = 8'd3;
    step("n3_s1", 1'b1, -90,  5'b10000);
    step("n3_s2", 1'b1, -90,  5'b10000);
    step("n3_s3", 1'b1, -120, 5'b10000);
    step("n3_s4", 1'b1, -90,  5'b10000);
    step("n3_s5", 1'b1, -90,  5'b10000);
    step("n3_s6", 1'b1, -90,  5'b10110);
    step("n3_s7", 1'b1, -90,  5'b10100);
    hold_samples = 8'd1;
    step("n3_down", 1'b1, -200, 5'b10001);
    hold_samples = 8'd2;
    step("gap_v1", 1'b1, -90,  5'b10000);
    step("gap_v0", 1'b0, -200, 5'b10000);
    step("gap_v2", 1'b1, -90,  5'b10110);
    step("gap_v0b", 1'b0, -200, 5'b10100);
    step("gap_l1", 1'b1, -200, 5'b10100);
    step("gap_l0", 1'b0, -90,  5'b10100);
    step("gap_l2", 1'b1, -200, 5'b10001);
    high_threshold = -14'sd150;
    low_threshold  = -14'sd100;
    hold_samples   = 8'd1;
    step("cfg_bad1", 1'b1, -50, 5'b11000);
    step("cfg_bad2", 1'b1, -50, 5'b11000);
    high_threshold = 14'(HIGH_THRESHOLD);
    low_threshold  = 14'(LOW_THRESHOLD);
    step("cfg_ok_rise", 1'b1, -50,  5'b10110);
    step("cfg_ok_fall", 1'b1, -200, 5'b10001);
    hold_samples = 8'd4;
    step("lowN_s1", 1'b1, -90, 5'b10000);
    step("lowN_s2", 1'b1, -90, 5'b10000);
    step("lowN_s3", 1'b1, -90, 5'b10000);
    hold_samples = 8'd2;
    step("lowN_s4", 1'b1, -90, 5'b10110);
    hold_samples = 8'd0;
    step("n0_fall", 1'b1, -200, 5'b10001);
    step("n0_rise", 1'b1, -90,  5'b10110);
    step("n0_fall2", 1'b1, -200, 5'b10001);
    hold_samples = 8'd4;
    step("rph_s1", 1'b1, -90, 5'b10000);
    step("rph_s2", 1'b1, -90, 5'b10000);
    reset_pulse("reset_pend_high");
    step("rph_f1", 1'b1, -90, 5'b10000);
    step("rph_f2", 1'b1, -90, 5'b10000);
    step("rph_f3", 1'b1, -90, 5'b10000);
    step("rph_f4", 1'b1, -90, 5'b10110);
    step("rpl_s1", 1'b1, -200, 5'b10100);
    step("rpl_s2", 1'b1, -200, 5'b10100);
    reset_pulse("reset_pend_low");
    step("rpl_idle", 1'b0, 0, 5'b10000);
    high_threshold = 14'sh1FFF;
    low_threshold  = 14'sh2000;
    hold_samples   = 8'd1;
    step("fs_8190",  1'b1, 8190,  5'b10000);
    step("fs_8191",  1'b1, 8191,  5'b10110);
    step("fs_0",     1'b1, 0,     5'b10100);
    step("fs_m8191", 1'b1, -8191, 5'b10100);
    step("fs_m8192", 1'b1, -8192, 5'b10001);
    s_axis_tvalid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL drain: pending=%0d expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
